output_stream_collector: RTL and testbench

OUTPUT_STREAM_COLLECTOR -- requirements
Module: output_stream_collector

---
 rtl/output_stream_collector_if.sv | 19 +
 rtl/output_stream_collector.sv | 164 ++++++++++++++++
 tb/tb_output_stream_collector.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_stream_collector_if.sv
// Host-side word stream of the output stream collector.
// The collector drives the master side; the host (or bench) uses the slave side.
interface output_stream_collector_if;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/output_stream_collector.sv
// Output stream collector: timestamps activations of four monitor streams,
// queues them as records in a small FIFO and drains each record to the host
// as a header word, optionally followed by the 64-bit value of stream 0.
module output_stream_collector #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [63:0]       output_0,
   input  logic                     output_0_aktv,
   input  logic                     output_1,
   input  logic                     output_1_aktv,
   input  logic                     output_2,
   input  logic                     output_2_aktv,
   input  logic                     output_3,
   input  logic                     output_3_aktv,
   output_stream_collector_if.master host,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [TS_W-1:0] ts;
      logic [3:0]      mask;
      logic [2:0]      b;
      logic [63:0]     v0;
   } rec_t;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      VAL
   } state_t;

   rec_t            mem [DEPTH];
   rec_t            new_rec;
   rec_t            head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   count;
   logic [TS_W-1:0] ts;
   logic [3:0]      mask;
   logic            capture;
   logic            push;
   logic            drop;
   logic            pop;
   logic            remaining;
   state_t          state;
   state_t          state_next;
   logic [63:0]     data_c;
   logic            valid_c;

   assign mask    = {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv};
   assign capture = en && (mask != 4'b0000);
   // Space is judged on the level before the edge, so a same-edge pop never makes room.
   assign push    = capture && (count != LW'(DEPTH));
   assign drop    = capture && (count == LW'(DEPTH));
   assign head    = mem[rd_ptr];
   // After the current pop, is anything left (including a record arriving this edge)?
   assign remaining = (count > LW'(1)) || push;

   assign fifo_level     = count;
   assign host.out_data  = data_c;
   assign host.out_valid = valid_c;

   // Assemble the record for this edge; inactive streams contribute zeros.
   always_comb begin
      new_rec.ts   = ts;
      new_rec.mask = mask;
      new_rec.b    = {output_3 & output_3_aktv, output_2 & output_2_aktv, output_1 & output_1_aktv};
      new_rec.v0   = output_0_aktv ? output_0 : 64'sd0;
   end

   // Record storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= new_rec;
      end
   end

   // Timestamp, FIFO pointers/level and drop bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts         <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= 16'd0;
      end else begin
         if (en) begin
            ts <= ts + TS_W'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + LW'(push) - LW'(pop);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end
      end
   end

   // Drain FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Drain FSM next state and host word; the word comes straight from the FIFO head,
   // which cannot change until the record's final word handshakes.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      valid_c    = 1'b0;
      data_c     = 64'd0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_next = HDR;
            end
         end
         HDR: begin
            valid_c = 1'b1;
            data_c  = {32'(head.ts), 21'd0, head.b, 4'd0, head.mask};
            if (host.out_ready) begin
               if (head.mask[0]) begin
                  state_next = VAL;
               end else begin
                  pop        = 1'b1;
                  state_next = remaining ? HDR : IDLE;
               end
            end
         end
         VAL: begin
            valid_c = 1'b1;
            data_c  = head.v0;
            if (host.out_ready) begin
               pop        = 1'b1;
               state_next = remaining ? HDR : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_output_stream_collector.sv
// Directed bench for output_stream_collector: a default instance (DEPTH=8, TS_W=32)
// and a narrow-timestamp instance (TS_W=4) share all stimulus.
module tb_output_stream_collector;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic signed [63:0] output_0 = 64'sd0;
   logic               output_0_aktv = 1'b0;
   logic               output_1 = 1'b0;
   logic               output_1_aktv = 1'b0;
   logic               output_2 = 1'b0;
   logic               output_2_aktv = 1'b0;
   logic               output_3 = 1'b0;
   logic               output_3_aktv = 1'b0;
   logic               out_ready = 1'b0;

   logic        overflow_a;
   logic        overflow_b;
   logic [15:0] drop_a;
   logic [15:0] drop_b;
   logic [3:0]  level_a;
   logic [3:0]  level_b;

   int total = 0;
   int bad = 0;
   int ts_model = 0;

   logic [31:0] rec_ts [10];
   logic [63:0] exp_w [2];
   logic [63:0] q [$];
   logic [31:0] cap;
   int          wi;

   output_stream_collector_if bus_a ();
   output_stream_collector_if bus_b ();

   assign bus_a.out_ready = out_ready;
   assign bus_b.out_ready = out_ready;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   output_stream_collector dut_a (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .output_0      (output_0),
      .output_0_aktv (output_0_aktv),
      .output_1      (output_1),
      .output_1_aktv (output_1_aktv),
      .output_2      (output_2),
      .output_2_aktv (output_2_aktv),
      .output_3      (output_3),
      .output_3_aktv (output_3_aktv),
      .host          (bus_a),
      .overflow      (overflow_a),
      .drop_count    (drop_a),
      .fifo_level    (level_a)
   );

   output_stream_collector #(.DEPTH(8), .TS_W(4)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .output_0      (output_0),
      .output_0_aktv (output_0_aktv),
      .output_1      (output_1),
      .output_1_aktv (output_1_aktv),
      .output_2      (output_2),
      .output_2_aktv (output_2_aktv),
      .output_3      (output_3),
      .output_3_aktv (output_3_aktv),
      .host          (bus_b),
      .overflow      (overflow_b),
      .drop_count    (drop_b),
      .fifo_level    (level_b)
   );

   function automatic logic [63:0] hdr(input logic [31:0] t, input logic [2:0] b, input logic [3:0] m);
      return {t, 21'd0, b, 4'd0, m};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic signed [63:0] v0, input logic a0,
                                input logic b1, input logic a1, input logic b2, input logic a2,
                                input logic b3, input logic a3);
      en            = e;
      output_0      = v0;
      output_0_aktv = a0;
      output_1      = b1;
      output_1_aktv = a1;
      output_2      = b2;
      output_2_aktv = a2;
      output_3      = b3;
      output_3_aktv = a3;
   endtask

   // One rising edge; the reference timestamp advances only if en was high at that edge.
   task automatic tick();
      if (en) ts_model++;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge arrives.
   task automatic doReset();
      applyStimulus(1'b0, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst_valid", 64'(bus_a.out_valid), 64'd0);
      checkOutput("rst_data", bus_a.out_data, 64'd0);
      checkOutput("rst_level", 64'(level_a), 64'd0);
      checkOutput("rst_overflow", 64'(overflow_a), 64'd0);
      checkOutput("rst_drops", 64'(drop_a), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ts_model = 0;
   endtask

   // Global guard so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      @(posedge clk);
      #1;

      // Single event at ts=500 with stream 0 active.
      doReset();
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      repeat (500) tick();
      applyStimulus(1'b1, 64'sd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_idle_after_capture", 64'(bus_a.out_valid), 64'd0);
      tick();
      checkOutput("t1_hdr_valid", 64'(bus_a.out_valid), 64'd1);
      checkOutput("t1_hdr", bus_a.out_data, 64'h0000_01F4_0000_0001);
      tick();
      checkOutput("t1_val_valid", 64'(bus_a.out_valid), 64'd1);
      checkOutput("t1_val", bus_a.out_data, 64'd1);
      tick();
      checkOutput("t1_done_valid", 64'(bus_a.out_valid), 64'd0);
      checkOutput("t1_done_level", 64'(level_a), 64'd0);

      // Boolean streams only, with a masked-off stream 2 and stream 0.
      doReset();
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      repeat (10) tick();
      applyStimulus(1'b1, 64'sd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("t2_hdr_valid", 64'(bus_a.out_valid), 64'd1);
      checkOutput("t2_hdr", bus_a.out_data, 64'h0000_000A_0000_010A);
      tick();
      checkOutput("t2_no_value_word", 64'(bus_a.out_valid), 64'd0);
      checkOutput("t2_level", 64'(level_a), 64'd0);

      // Overflow: 10 events into an 8-deep FIFO while the host stalls, then drain with en low.
      doReset();
      for (int i = 0; i < 10; i++) begin
         rec_ts[i] = 32'(ts_model);
         applyStimulus(1'b1, 64'(100 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_level_full", 64'(level_a), 64'd8);
      checkOutput("t3_overflow", 64'(overflow_a), 64'd1);
      checkOutput("t3_drops", 64'(drop_a), 64'd2);
      checkOutput("t3_stalled_hdr", bus_a.out_data, hdr(rec_ts[0], 3'b000, 4'b0001));
      applyStimulus(1'b0, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         checkOutput("t3_stream_valid", 64'(bus_a.out_valid), 64'd1);
         if (j % 2 == 0)
            checkOutput("t3_stream_hdr", bus_a.out_data, hdr(rec_ts[j / 2], 3'b000, 4'b0001));
         else
            checkOutput("t3_stream_val", bus_a.out_data, 64'(100 + j / 2));
         tick();
      end
      checkOutput("t3_idle_valid", 64'(bus_a.out_valid), 64'd0);
      checkOutput("t3_idle_level", 64'(level_a), 64'd0);

      // Negative value with the host toggling ready every cycle.
      doReset();
      cap = 32'(ts_model);
      applyStimulus(1'b1, -64'sd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp_w[0] = hdr(cap, 3'b000, 4'b0001);
      exp_w[1] = 64'hFFFF_FFFF_FFFF_FFFB;
      wi = 0;
      for (int c = 0; c < 12; c++) begin
         out_ready = (c % 2 == 1);
         if (bus_a.out_valid) begin
            if (wi < 2)
               checkOutput("t4_word", bus_a.out_data, exp_w[wi]);
            else
               checkOutput("t4_extra_valid", 64'(bus_a.out_valid), 64'd0);
            if (out_ready) wi++;
         end
         tick();
      end
      checkOutput("t4_word_count", 64'(wi), 64'd2);
      checkOutput("t4_idle_valid", 64'(bus_a.out_valid), 64'd0);

      // Narrow timestamp wraps; en low ignores activations and freezes ts.
      doReset();
      out_ready = 1'b1;
      q.delete();
      for (int c = 0; c < 20; c++) begin
         if (c == 15 || c == 17)
            applyStimulus(1'b1, 64'(c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         else
            applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         if (bus_b.out_valid) q.push_back(bus_b.out_data);
      end
      applyStimulus(1'b0, 64'sd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (6) begin
         tick();
         if (bus_b.out_valid) q.push_back(bus_b.out_data);
      end
      checkOutput("t5_word_count", 64'(q.size()), 64'd4);
      checkOutput("t5_hdr_ts15", q.size() > 0 ? q[0] : 64'd0, 64'h0000_000F_0000_0001);
      checkOutput("t5_val15", q.size() > 1 ? q[1] : 64'd0, 64'd15);
      checkOutput("t5_hdr_ts1", q.size() > 2 ? q[2] : 64'd0, 64'h0000_0001_0000_0001);
      checkOutput("t5_val17", q.size() > 3 ? q[3] : 64'd0, 64'd17);
      checkOutput("t5_en_low_level", 64'(level_b), 64'd0);
      checkOutput("t5_en_low_drops", 64'(drop_b), 64'd0);
      checkOutput("t5_en_low_overflow", 64'(overflow_b), 64'd0);
      applyStimulus(1'b1, 64'sd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("t5_ts_held_hdr", bus_b.out_data, 64'h0000_0004_0000_0001);

      // Reset while the value word is on the bus with three records queued.
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'(200 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("t6_val_valid", 64'(bus_a.out_valid), 64'd1);
      checkOutput("t6_val_data", bus_a.out_data, 64'd200);
      checkOutput("t6_queued_level", 64'(level_a), 64'd3);
      doReset();
      cap = 32'(ts_model);
      out_ready = 1'b1;
      applyStimulus(1'b1, 64'sd77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 64'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      q.delete();
      repeat (6) begin
         tick();
         if (bus_a.out_valid) q.push_back(bus_a.out_data);
      end
      checkOutput("t6_word_count", 64'(q.size()), 64'd2);
      checkOutput("t6_fresh_hdr", q.size() > 0 ? q[0] : 64'd0, hdr(cap, 3'b000, 4'b0001));
      checkOutput("t6_fresh_val", q.size() > 1 ? q[1] : 64'd0, 64'd77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
